// File: rtl/vram_port_sched.sv
// Two-port VRAM access scheduler: per-port address/step registers, single-entry write buffer and read prefetch.
// One-cycle registered strobe after a request; held until vram_ack; a full write buffer drops the write (wr_ovf).
module vram_port_sched #(
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              addrsel,
  input  logic [2:0]        addr_wr,
  input  logic [7:0]        addr_wrdata,
  input  logic [1:0]        data_wr,
  input  logic [7:0]        data_wrdata,
  input  logic [1:0]        data_rd,
  output logic [7:0]        rd_data0,
  output logic [7:0]        rd_data1,
  output logic [ADDR_W-1:0] addr0,
  output logic [ADDR_W-1:0] addr1,
  output logic [1:0]        busy,
  output logic              wr_ovf,
  output logic              vram_strobe,
  output logic              vram_write,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [7:0]        vram_wrdata,
  input  logic              vram_ack,
  input  logic [7:0]        vram_rddata
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q [2];
  logic [ADDR_W-1:0] addr_d [2];
  logic [3:0]        incr_q [2];
  logic [3:0]        incr_d [2];
  logic              decr_q [2];
  logic              decr_d [2];
  logic [7:0]        rdd_q  [2];
  logic [ADDR_W-1:0] wb_addr [2];
  logic [7:0]        wb_dat  [2];
  logic [1:0]        rd_pend, wr_pend;
  logic [1:0]        aw_hit, wr_ack, rd_ack, wr_acc, wr_drop, ev, rd_ok, in_flight;
  logic              cur_port, rr_q, stale_q, issue, gnt;
  logic              unused_bits;

  assign unused_bits = ^addr_wrdata[2:1];

  function automatic logic [ADDR_W-1:0] step_of(input logic [3:0] idx);
    logic [9:0] s;
    case (idx)
      4'd0:    s = 10'd0;
      4'd1:    s = 10'd1;
      4'd2:    s = 10'd2;
      4'd3:    s = 10'd4;
      4'd4:    s = 10'd8;
      4'd5:    s = 10'd16;
      4'd6:    s = 10'd32;
      4'd7:    s = 10'd64;
      4'd8:    s = 10'd128;
      4'd9:    s = 10'd256;
      4'd10:   s = 10'd512;
      4'd11:   s = 10'd40;
      4'd12:   s = 10'd80;
      4'd13:   s = 10'd160;
      4'd14:   s = 10'd320;
      default: s = 10'd640;
    endcase
    return {{(ADDR_W-10){1'b0}}, s};
  endfunction

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      in_flight[p] = (state_q == ACCESS) && (cur_port == 1'(p));
      aw_hit[p]    = (|addr_wr) && (addrsel == 1'(p));
      wr_ack[p]    = in_flight[p] && vram_ack && vram_write;
      rd_ack[p]    = in_flight[p] && vram_ack && !vram_write;
      // A write ack frees the buffer in the same cycle.
      wr_acc[p]    = data_wr[p] && (!wr_pend[p] || wr_ack[p]);
      wr_drop[p]   = data_wr[p] && wr_pend[p] && !wr_ack[p];
      ev[p]        = aw_hit[p] || wr_acc[p] || data_rd[p];
      rd_ok[p]     = rd_ack[p] && !stale_q && !ev[p];
      addr_d[p]    = addr_q[p];
      incr_d[p]    = incr_q[p];
      decr_d[p]    = decr_q[p];
      if (aw_hit[p]) begin
        if (addr_wr[0]) addr_d[p][7:0]  = addr_wrdata;
        if (addr_wr[1]) addr_d[p][15:8] = addr_wrdata;
        if (addr_wr[2]) begin
          addr_d[p][16] = addr_wrdata[0];
          incr_d[p]     = addr_wrdata[7:4];
          decr_d[p]     = addr_wrdata[3];
        end
      end else if (wr_acc[p] || data_rd[p]) begin
        addr_d[p] = decr_q[p] ? addr_q[p] - step_of(incr_q[p])
                              : addr_q[p] + step_of(incr_q[p]);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    gnt     = rr_q;
    case (state_q)
      IDLE: begin
        if (|(wr_pend | rd_pend)) begin
          issue   = 1'b1;
          gnt     = (wr_pend[rr_q] || rd_pend[rr_q]) ? rr_q : ~rr_q;
          state_d = ACCESS;
        end
      end
      ACCESS:  if (vram_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_q        <= 1'b0;
      cur_port    <= 1'b0;
      stale_q     <= 1'b0;
      vram_strobe <= 1'b0;
      vram_write  <= 1'b0;
      vram_addr   <= '0;
      vram_wrdata <= '0;
      wr_ovf      <= 1'b0;
      rd_pend     <= '0;
      wr_pend     <= '0;
      for (int p = 0; p < 2; p++) begin
        addr_q[p]  <= '0;
        incr_q[p]  <= '0;
        decr_q[p]  <= 1'b0;
        rdd_q[p]   <= '0;
        wb_addr[p] <= '0;
        wb_dat[p]  <= '0;
      end
    end else begin
      state_q <= state_d;
      wr_ovf  <= wr_ovf | (|wr_drop);
      if (issue) begin
        // Pending write wins over fetch; fetch address is frozen here.
        vram_strobe <= 1'b1;
        vram_write  <= wr_pend[gnt];
        vram_addr   <= wr_pend[gnt] ? wb_addr[gnt] : addr_q[gnt];
        vram_wrdata <= wb_dat[gnt];
        cur_port    <= gnt;
        stale_q     <= ev[gnt];
        rr_q        <= ~gnt;
      end else if (state_q == ACCESS) begin
        stale_q <= stale_q | ev[cur_port];
        if (vram_ack) vram_strobe <= 1'b0;
      end
      for (int p = 0; p < 2; p++) begin
        addr_q[p] <= addr_d[p];
        incr_q[p] <= incr_d[p];
        decr_q[p] <= decr_d[p];
        if (ev[p])         rd_pend[p] <= 1'b1;
        else if (rd_ok[p]) rd_pend[p] <= 1'b0;
        if (rd_ok[p])      rdd_q[p]   <= vram_rddata;
        if (wr_acc[p]) begin
          wr_pend[p] <= 1'b1;
          wb_addr[p] <= addr_q[p];
          wb_dat[p]  <= data_wrdata;
        end else if (wr_ack[p]) begin
          wr_pend[p] <= 1'b0;
        end
      end
    end
  end

  assign addr0    = addr_q[0];
  assign addr1    = addr_q[1];
  assign rd_data0 = rdd_q[0];
  assign rd_data1 = rdd_q[1];
  assign busy     = wr_pend | rd_pend | in_flight;

endmodule

// File: tb/tb_vram_port_sched.sv
// Scoreboard bench: expected VRAM accesses queued by stimulus, checked by a monitor on each new strobe.
module tb_vram_port_sched;
  localparam int AW = 17;

  logic          clk = 1'b0;
  logic          rst_n, addrsel;
  logic [2:0]    addr_wr;
  logic [7:0]    addr_wrdata, data_wrdata;
  logic [1:0]    data_wr, data_rd;
  logic [7:0]    rd_data0, rd_data1, vram_wrdata;
  logic [AW-1:0] addr0, addr1, vram_addr;
  logic [1:0]    busy;
  logic          wr_ovf, vram_strobe, vram_write;
  logic          vram_ack = 1'b0;
  logic [7:0]    vram_rddata = 8'h00;

  always #5 clk = ~clk;

  vram_port_sched #(.ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .addrsel(addrsel), .addr_wr(addr_wr),
    .addr_wrdata(addr_wrdata), .data_wr(data_wr), .data_wrdata(data_wrdata),
    .data_rd(data_rd), .rd_data0(rd_data0), .rd_data1(rd_data1),
    .addr0(addr0), .addr1(addr1), .busy(busy), .wr_ovf(wr_ovf),
    .vram_strobe(vram_strobe), .vram_write(vram_write), .vram_addr(vram_addr),
    .vram_wrdata(vram_wrdata), .vram_ack(vram_ack), .vram_rddata(vram_rddata)
  );

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [7:0]    dat;
  } acc_t;

  acc_t       exp_q[$];
  int         chk = 0;
  int         err = 0;
  int         ack_dly = 1;
  logic       inject_ack = 1'b0;
  logic       prev_strobe = 1'b0;
  int         cnt = 0;
  logic [7:0] wmem [int];

  // Unwritten locations read back as a fixed pattern of their low address byte.
  function automatic logic [7:0] mem_rd(input logic [AW-1:0] a);
    if (wmem.exists(int'(a))) return wmem[int'(a)];
    return a[7:0] ^ 8'h5A;
  endfunction

  always @(negedge clk) begin
    vram_ack = 1'b0;
    if (inject_ack) begin
      vram_ack    = 1'b1;
      vram_rddata = 8'hEE;
      cnt         = 0;
    end else if (vram_strobe) begin
      cnt = cnt + 1;
      if (cnt >= ack_dly) begin
        vram_ack    = 1'b1;
        vram_rddata = mem_rd(vram_addr);
        if (vram_write) wmem[int'(vram_addr)] = vram_wrdata;
        cnt = 0;
      end
    end else begin
      cnt = 0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk = chk + 1;
    if (act !== exp) begin
      err = err + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic w, input logic [AW-1:0] a, input logic [7:0] d);
    acc_t e;
    e.wr = w; e.addr = a; e.dat = d;
    exp_q.push_back(e);
  endtask

  task automatic monitor();
    acc_t e;
    forever begin
      @(negedge clk);
      if (vram_strobe && !prev_strobe) begin
        if (exp_q.size() == 0) begin
          chk = chk + 1;
          err = err + 1;
          $display("FAIL unexpected_access: got wr=%0b addr=%0h expected none", vram_write, vram_addr);
        end else begin
          e = exp_q.pop_front();
          check("acc_wr", 32'(vram_write), 32'(e.wr));
          check("acc_addr", 32'(vram_addr), 32'(e.addr));
          if (e.wr) check("acc_dat", 32'(vram_wrdata), 32'(e.dat));
        end
      end
      prev_strobe = vram_strobe;
    end
  endtask

  // All drive tasks are entered at a falling edge and leave at the next one.
  task automatic aw(input logic sel, input logic [2:0] which, input logic [7:0] d);
    addrsel = sel; addr_wr = which; addr_wrdata = d;
    @(negedge clk);
    addr_wr = 3'b000;
  endtask

  task automatic dwr(input logic [1:0] m, input logic [7:0] d);
    data_wr = m; data_wrdata = d;
    @(negedge clk);
    data_wr = 2'b00;
  endtask

  task automatic drd(input logic [1:0] m);
    data_rd = m;
    @(negedge clk);
    data_rd = 2'b00;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy != 2'b00 || vram_strobe) && n < 300) begin
      @(negedge clk);
      n = n + 1;
    end
    if (n >= 300) begin
      chk = chk + 1;
      err = err + 1;
      $display("FAIL idle_timeout: got busy=%0b expected 0", busy);
    end
  endtask

  task automatic wait_strobe();
    int n = 0;
    while (!vram_strobe && n < 50) begin
      @(negedge clk);
      n = n + 1;
    end
    if (n >= 50) begin
      chk = chk + 1;
      err = err + 1;
      $display("FAIL strobe_timeout: got strobe=0 expected 1");
    end
  endtask

  typedef struct packed {
    logic          is_rd;
    logic [2:0]    which;
    logic [7:0]    d;
    logic [AW-1:0] fetch;
  } p1_t;

  task automatic stimulus();
    p1_t tbl [10];
    int  n;
    rst_n = 1'b0; addrsel = 1'b0; addr_wr = 3'b000; addr_wrdata = 8'h00;
    data_wr = 2'b00; data_wrdata = 8'h00; data_rd = 2'b00;
    repeat (3) @(negedge clk);
    check("rst_addr0", 32'(addr0), 32'h0);
    check("rst_addr1", 32'(addr1), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_strobe", 32'(vram_strobe), 32'h0);
    check("rst_rd_data0", 32'(rd_data0), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Address setup: first fetch (addr 0) is overtaken by the later byte writes.
    ack_dly = 1;
    push(1'b0, 17'h00000, 8'h00);
    push(1'b0, 17'h04000, 8'h00);
    aw(1'b0, 3'b001, 8'h00);
    aw(1'b0, 3'b010, 8'h40);
    aw(1'b0, 3'b100, 8'h10);
    wait_idle();
    check("setup_addr0", 32'(addr0), 32'h04000);
    check("setup_rd_data0", 32'(rd_data0), 32'h5A);
    check("setup_addr1", 32'(addr1), 32'h0);

    for (int i = 0; i < 4; i++) begin
      push(1'b1, 17'h04000 + 17'(i), 8'hA1 + 8'(i));
      push(1'b0, 17'h04001 + 17'(i), 8'h00);
      dwr(2'b01, 8'hA1 + 8'(i));
      wait_idle();
    end
    check("wr4_addr0", 32'(addr0), 32'h04004);
    check("wr4_ovf", 32'(wr_ovf), 32'h0);
    check("wr4_rd_data0", 32'(rd_data0), 32'h5E);

    push(1'b0, 17'h04000, 8'h00);
    aw(1'b0, 3'b001, 8'h00);
    wait_idle();
    check("rd_seq0", 32'(rd_data0), 32'hA1);
    for (int i = 1; i <= 4; i++) begin
      push(1'b0, 17'h04000 + 17'(i), 8'h00);
      drd(2'b01);
      wait_idle();
      check("rd_seq", 32'(rd_data0), (i < 4) ? 32'(8'hA1 + 8'(i)) : 32'h5E);
    end
    check("rd_seq_addr0", 32'(addr0), 32'h04004);

    // Round-robin: port 0 re-requests while in flight, port 1 must still get the next grant.
    ack_dly = 2;
    push(1'b0, 17'h00000, 8'h00);
    aw(1'b1, 3'b100, 8'h10);
    wait_idle();
    push(1'b0, 17'h04005, 8'h00);
    push(1'b0, 17'h00001, 8'h00);
    push(1'b0, 17'h04006, 8'h00);
    drd(2'b11);
    wait_strobe();
    drd(2'b01);
    wait_idle();
    push(1'b0, 17'h00002, 8'h00);
    push(1'b0, 17'h04007, 8'h00);
    drd(2'b11);
    wait_idle();
    check("rr_rd_data0", 32'(rd_data0), 32'h5D);
    check("rr_rd_data1", 32'(rd_data1), 32'h58);
    check("rr_addr0", 32'(addr0), 32'h04007);
    check("rr_addr1", 32'(addr1), 32'h00002);

    // New write landing in the write-ack cycle is accepted.
    push(1'b1, 17'h04007, 8'hB3);
    push(1'b1, 17'h04008, 8'hB4);
    push(1'b0, 17'h04009, 8'h00);
    dwr(2'b01, 8'hB3);
    n = 0;
    do begin
      @(negedge clk); #2;
      n = n + 1;
    end while (!vram_ack && n < 50);
    data_wr = 2'b01; data_wrdata = 8'hB4;
    @(negedge clk);
    data_wr = 2'b00;
    wait_idle();
    check("ackwr_addr0", 32'(addr0), 32'h04009);
    check("ackwr_ovf", 32'(wr_ovf), 32'h0);
    check("ackwr_rd_data0", 32'(rd_data0), 32'h53);

    ack_dly = 3;
    push(1'b1, 17'h04009, 8'hB1);
    push(1'b0, 17'h0400A, 8'h00);
    dwr(2'b01, 8'hB1);
    dwr(2'b01, 8'hB2);
    wait_idle();
    check("ovf_addr0", 32'(addr0), 32'h0400A);
    check("ovf_flag", 32'(wr_ovf), 32'h1);
    check("ovf_rd_data0", 32'(rd_data0), 32'h50);

    // Port 1 wrap, decrement and large-step table entries.
    ack_dly = 1;
    tbl[0] = '{1'b0, 3'b100, 8'h11, 17'h10002};
    tbl[1] = '{1'b0, 3'b001, 8'hFF, 17'h100FF};
    tbl[2] = '{1'b0, 3'b010, 8'hFF, 17'h1FFFF};
    tbl[3] = '{1'b1, 3'b000, 8'h00, 17'h00000};
    tbl[4] = '{1'b0, 3'b100, 8'h18, 17'h00000};
    tbl[5] = '{1'b1, 3'b000, 8'h00, 17'h1FFFF};
    tbl[6] = '{1'b0, 3'b100, 8'hB1, 17'h1FFFF};
    tbl[7] = '{1'b1, 3'b000, 8'h00, 17'h00027};
    tbl[8] = '{1'b0, 3'b100, 8'hF8, 17'h00027};
    tbl[9] = '{1'b1, 3'b000, 8'h00, 17'h1FDA7};
    for (int i = 0; i < 10; i++) begin
      push(1'b0, tbl[i].fetch, 8'h00);
      if (tbl[i].is_rd) drd(2'b10);
      else aw(1'b1, tbl[i].which, tbl[i].d);
      wait_idle();
      if (tbl[i].is_rd) check("p1_addr", 32'(addr1), 32'(tbl[i].fetch));
    end
    check("p1_rd_data1", 32'(rd_data1), 32'hFD);

    // Address rewrite during an in-flight fetch forces a refetch.
    ack_dly = 3;
    push(1'b0, 17'h04002, 8'h00);
    push(1'b0, 17'h04003, 8'h00);
    aw(1'b0, 3'b001, 8'h02);
    wait_strobe();
    aw(1'b0, 3'b001, 8'h03);
    wait_idle();
    check("stale_rd_data0", 32'(rd_data0), 32'hA4);
    check("stale_addr0", 32'(addr0), 32'h04003);

    // Reset in the middle of an access, then a late ack that must be ignored.
    push(1'b0, 17'h04004, 8'h00);
    drd(2'b01);
    wait_strobe();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    inject_ack = 1'b1;
    repeat (2) @(negedge clk);
    inject_ack = 1'b0;
    repeat (2) @(negedge clk);
    check("rst2_addr0", 32'(addr0), 32'h0);
    check("rst2_addr1", 32'(addr1), 32'h0);
    check("rst2_rd_data0", 32'(rd_data0), 32'h0);
    check("rst2_busy", 32'(busy), 32'h0);
    check("rst2_strobe", 32'(vram_strobe), 32'h0);
    check("rst2_ovf", 32'(wr_ovf), 32'h0);

    ack_dly = 1;
    push(1'b0, 17'h00000, 8'h00);
    drd(2'b01);
    wait_idle();
    check("step0_addr0", 32'(addr0), 32'h0);
    check("step0_rd_data0", 32'(rd_data0), 32'h5A);
    repeat (2) @(negedge clk);
    check("exp_q_empty", 32'(exp_q.size()), 32'h0);
  endtask

  initial begin
    fork
      monitor();
      stimulus();
      begin
        #500000;
        chk = chk + 1;
        err = err + 1;
        $display("FAIL global_timeout: got running expected done");
      end
    join_any
    $display("Result: errors=%0d of %0d checks", err, chk);
    $finish;
  end

endmodule
